qspi_cmd_packer: RTL

- Parameterised host-side command packer for the QSPI flash controller.
- Accepts a header word, then N payload words, from the PC link (HOST_W bits each) and packs them into a byte-wide command buffer.
- Triggers the memory controller, then tracks the controller's busy handshake to completion.
- Adds over-length rejection, an acknowledge timeout and a configurable trigger stretch for slower controller clocks.

---
 rtl/qspi_cmd_packer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/qspi_cmd_packer.sv
// qspi_cmd_packer: collects a header word plus N payload words from the host
// link into a byte-wide command buffer. It then fires a stretched trigger to
// the QSPI memory controller and follows its busy handshake to completion.
// Over-long headers are absorbed without touching the buffer. A missing
// acknowledge is reported as a timeout.
// Optional build macro QSPI_CMD_PACKER_STATS_EN adds saturating command/failure
// counters (cmd_count, fail_count).
module qspi_cmd_packer #(
  parameter int HOST_W    = 32,
  parameter int MAX_BYTES = 259,
  parameter int TRIG_HOLD = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   RESET_N,
  input  logic                   wr,
  input  logic [HOST_W-1:0]      host_data,
  output logic                   busy,
  output logic                   len_err,
  output logic                   error,
  output logic                   timeout_err,
  output logic [2:0]             state,
  output logic                   mc_trigger,
  output logic                   mc_quad,
  output logic [7:0]             mc_cmd,
  output logic [MAX_BYTES*8-1:0] mc_data,
  input  logic                   mc_busy,
  input  logic                   mc_error
`ifdef QSPI_CMD_PACKER_STATS_EN
  ,
  output logic [15:0]            cmd_count,
  output logic [15:0]            fail_count
`endif
);

  localparam int BPW       = HOST_W / 8;
  localparam int MAX_WORDS = (MAX_BYTES + BPW - 1) / BPW;
  localparam int DW        = MAX_BYTES * 8;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam int HW        = (TRIG_HOLD > 1) ? $clog2(TRIG_HOLD) : 1;
  // len is 8 bits wide, so any capacity above 256 words can never be exceeded
  localparam logic [8:0] MAXW9 = (MAX_WORDS > 256) ? 9'd256 : 9'(MAX_WORDS);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    IDLE      = 3'd1,
    LOAD      = 3'd2,
    TRIG      = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5,
    DROP      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            len_err_q, len_err_d;
  logic            to_err_q, to_err_d;
  logic            trig_q, trig_d;
  logic            quad_q, quad_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   to_inc;
  logic            hdr_too_long;

  assign to_inc       = to_q + 1'b1;
  assign hdr_too_long = {1'b0, host_data[15:8]} > MAXW9;

  // state register
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) state_q <= BOOT;
    else          state_q <= state_d;
  end

  // next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    len_err_d = len_err_q;
    to_err_d  = to_err_q;
    trig_d    = trig_q;
    quad_d    = quad_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    hold_d    = hold_q;
    case (state_q)
      BOOT: if (!mc_busy) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      IDLE: if (wr) begin
        cmd_d     = host_data[7:0];
        quad_d    = host_data[16];
        cnt_d     = host_data[15:8];
        len_err_d = 1'b0;
        to_err_d  = 1'b0;
        to_d      = '0;
        busy_d    = 1'b1;
        if (hdr_too_long) begin
          len_err_d = 1'b1;
          state_d   = DROP;
        end else begin
          state_d   = LOAD;
        end
      end
      LOAD: if (cnt_q == 8'd0) begin
        state_d = TRIG;
        trig_d  = 1'b1;
        hold_d  = '0;
      end else if (wr) begin
        // oldest words fall off the top; the newest sits in the low bits
        data_d = {data_q[DW-HOST_W-1:0], host_data};
        cnt_d  = cnt_q - 8'd1;
      end
      TRIG: if (hold_q == HW'(TRIG_HOLD - 1)) begin
        trig_d  = 1'b0;
        state_d = WAIT_ACK;
      end else begin
        hold_d  = hold_q + 1'b1;
      end
      WAIT_ACK: if (mc_busy) begin
        // acknowledge takes priority over a timeout expiring this same cycle
        state_d = WAIT_DONE;
      end else begin
        to_d = to_inc;
        if (to_inc == TW'(TIMEOUT)) begin
          to_err_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      WAIT_DONE: if (!mc_busy) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      DROP: if (cnt_q == 8'd0) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end else if (wr) begin
        cnt_d = cnt_q - 8'd1;
      end
      default: state_d = BOOT;
    endcase
  end

  // datapath registers; reset drops the trigger immediately
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q    <= 1'b1;
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      trig_q    <= 1'b0;
      quad_q    <= 1'b0;
      cmd_q     <= 8'd0;
      data_q    <= '0;
      cnt_q     <= 8'd0;
      to_q      <= '0;
      hold_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
      to_err_q  <= to_err_d;
      trig_q    <= trig_d;
      quad_q    <= quad_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      hold_q    <= hold_d;
    end
  end

`ifdef QSPI_CMD_PACKER_STATS_EN
  logic [15:0] cmd_cnt_q, fail_cnt_q;
  logic        done_ev, fail_ev;

  assign done_ev = (state_q == WAIT_DONE) && (state_d == IDLE);
  assign fail_ev = ((state_q == IDLE) && (state_d == DROP)) ||
                   ((state_q == WAIT_ACK) && (state_d == IDLE));

  // saturating completion / failure counters
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_cnt_q  <= 16'd0;
      fail_cnt_q <= 16'd0;
    end else begin
      if (done_ev && cmd_cnt_q != 16'hFFFF)  cmd_cnt_q  <= cmd_cnt_q + 16'd1;
      if (fail_ev && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
    end
  end

  assign cmd_count  = cmd_cnt_q;
  assign fail_count = fail_cnt_q;
`endif

  assign busy        = busy_q;
  assign len_err     = len_err_q;
  assign timeout_err = to_err_q;
  assign error       = mc_error | to_err_q;
  assign state       = state_q;
  assign mc_trigger  = trig_q;
  assign mc_quad     = quad_q;
  assign mc_cmd      = cmd_q;
  assign mc_data     = data_q;

endmodule
